// File: rtl/march_pkg.sv
// Shared definitions for the March C- stimulus sequencer.
// Each march element is described by its address direction, its number of
// ops per address, and the write/read kind and data polarity of each op.
package march_pkg;

   // March element encoding; ELEM_IDLE is shown whenever no run is active.
   localparam logic [2:0] M0        = 3'd0;
   localparam logic [2:0] M1        = 3'd1;
   localparam logic [2:0] M2        = 3'd2;
   localparam logic [2:0] M3        = 3'd3;
   localparam logic [2:0] M4        = 3'd4;
   localparam logic [2:0] M5        = 3'd5;
   localparam logic [2:0] ELEM_IDLE = 3'd7;

   // Background pattern for a logical "0"; a logical "1" is its inverse.
   localparam logic [3:0] BG0_DEFAULT = 4'b0000;

   // Sequencer FSM states, exported on a debug port.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Direction bit: 1 = descending addresses (M3, M4), 0 = ascending.
   function automatic logic elem_down(input logic [2:0] e);
      return (e == M3) || (e == M4);
   endfunction

   // Ops per address: the read/write pairs M1..M4 issue two, M0/M5 one.
   function automatic logic [1:0] elem_ops(input logic [2:0] e);
      logic [1:0] n;
      case (e)
         M1, M2, M3, M4: n = 2'd2;
         default:        n = 2'd1;
      endcase
      return n;
   endfunction

   // Op kind table: 1 = write, 0 = read. p is the op index at an address.
   //   M0: w0   M1: r0,w1   M2: r1,w0   M3: r0,w1   M4: r1,w0   M5: r0
   function automatic logic op_is_write(input logic [2:0] e, input logic p);
      logic w;
      case (e)
         M0:             w = 1'b1;
         M1, M2, M3, M4: w = p;
         default:        w = 1'b0;
      endcase
      return w;
   endfunction

   // Data polarity table: 1 = pattern "1" (~BG0), 0 = pattern "0" (BG0).
   function automatic logic op_is_one(input logic [2:0] e, input logic p);
      logic one;
      case (e)
         M1, M3:  one = p;
         M2, M4:  one = ~p;
         default: one = 1'b0;
      endcase
      return one;
   endfunction

endpackage

// File: rtl/march_c_sequencer_if.sv
// SRAM-side bus of the March C- sequencer.
// Handshake: there is no valid/ready; the sequencer issues exactly one op per
// cycle while busy (WE=1 write, WE=0 read with Data_in = expected value), and
// Compare_en is a single-cycle strobe telling the comparator that the SRAM
// read data of that cycle must equal Expected. Nothing may stall the bus.
interface march_c_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
);
   logic [ADDR_W-1:0] Address;
   logic              WE;
   logic [DATA_W-1:0] Data_in;
   logic [DATA_W-1:0] Expected;
   logic              Compare_en;

   // The sequencer drives every bus signal.
   modport master (
      output Address,
      output WE,
      output Data_in,
      output Expected,
      output Compare_en
   );

   // SRAM and comparator only observe the bus.
   modport slave (
      input Address,
      input WE,
      input Data_in,
      input Expected,
      input Compare_en
   );
endinterface

// File: rtl/march_addr_ctr.sv
// Address counter for one march element: loads the element's first address
// (0 when ascending, all-ones when descending), steps in the loaded direction
// and flags the element's terminal address. It never wraps on its own; a new
// element always starts with a load.
module march_addr_ctr #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_load_down,
   input  logic              i_step,
   output logic [ADDR_W-1:0] o_count,
   output logic              o_tc
);
   localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

   logic [ADDR_W-1:0] r_count;
   logic              r_down;
   logic              w_tc;

   // Load start address and direction, otherwise step until the terminal address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_down  <= 1'b0;
      end else if (i_load) begin
         r_down  <= i_load_down;
         r_count <= i_load_down ? CNT_MAX : '0;
      end else if (i_step && !w_tc) begin
         r_count <= r_down ? (r_count - 1'b1) : (r_count + 1'b1);
      end
   end

   assign w_tc    = r_down ? (r_count == '0) : (r_count == CNT_MAX);
   assign o_count = r_count;
   assign o_tc    = w_tc;

endmodule

// File: rtl/march_c_sequencer.sv
// March C- stimulus sequencer for the SRAM BIST path:
//   M0 up(w0)  M1 up(r0,w1)  M2 up(r1,w0)  M3 down(r0,w1)  M4 down(r1,w0)  M5 up(r0)
// The FSM state, element, op phase and address counter always describe the
// op being driven in the current cycle, so the bus is decoded from them.
// Each read also enters a READ_LAT-deep pipeline that re-times the expected
// value and compare strobe to the SRAM read latency (legal range 1..3).
module march_c_sequencer
   import march_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 4,
   parameter int                READ_LAT = 1,
   parameter logic [DATA_W-1:0] BG0      = BG0_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   march_c_sequencer_if.master        bus,
   output logic [2:0]                 Elem,
   output logic                       Busy,
   output logic                       Done,
   output state_t                     o_state
);
   // DRAIN lasts READ_LAT cycles; the counter runs 0..READ_LAT-1.
   localparam logic [1:0] DRAIN_LAST = 2'(READ_LAT - 1);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_elem, w_elem_nxt;
   logic              r_phase, w_phase_nxt;
   logic [1:0]        r_drain_cnt, w_drain_cnt_nxt;

   logic              w_ctr_load;
   logic              w_ctr_load_down;
   logic              w_ctr_step;
   logic              w_ctr_tc;
   logic [ADDR_W-1:0] w_ctr_count;

   logic [2:0]        w_elem_inc;
   logic              w_two_ops;
   logic              w_op_write;
   logic              w_op_one;

   logic [ADDR_W-1:0] w_address;
   logic              w_we;
   logic [DATA_W-1:0] w_data_in;
   logic [DATA_W-1:0] w_pipe_exp;
   logic              w_pipe_cmp;

   // Entry layout: {expected data, compare strobe}.
   logic [DATA_W:0]   r_pipe [READ_LAT];

   march_addr_ctr #(
      .ADDR_W (ADDR_W)
   ) u_addr_ctr (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_ctr_load),
      .i_load_down (w_ctr_load_down),
      .i_step      (w_ctr_step),
      .o_count     (w_ctr_count),
      .o_tc        (w_ctr_tc)
   );

   // Decode the current op from the element tables.
   always_comb begin
      w_elem_inc = r_elem + 3'd1;
      w_two_ops  = (elem_ops(r_elem) == 2'd2);
      w_op_write = op_is_write(r_elem, r_phase);
      w_op_one   = op_is_one(r_elem, r_phase);
   end

   // FSM state register together with element, op phase and drain counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_elem      <= M0;
         r_phase     <= 1'b0;
         r_drain_cnt <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_elem      <= w_elem_nxt;
         r_phase     <= w_phase_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
      end
   end

   // Next-state: walk ops within an address, addresses within an element,
   // then elements; start is only honoured when no run is in progress.
   always_comb begin
      w_state_nxt     = r_state;
      w_elem_nxt      = r_elem;
      w_phase_nxt     = r_phase;
      w_drain_cnt_nxt = r_drain_cnt;
      w_ctr_load      = 1'b0;
      w_ctr_load_down = 1'b0;
      w_ctr_step      = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt     = ST_RUN;
               w_elem_nxt      = M0;
               w_phase_nxt     = 1'b0;
               w_ctr_load      = 1'b1;
               w_ctr_load_down = elem_down(M0);
            end
         end
         ST_RUN: begin
            if (w_two_ops && !r_phase) begin
               // Read done at this address; the write follows at the same address.
               w_phase_nxt = 1'b1;
            end else begin
               w_phase_nxt = 1'b0;
               if (!w_ctr_tc) begin
                  w_ctr_step = 1'b1;
               end else if (r_elem == M5) begin
                  w_state_nxt     = ST_DRAIN;
                  w_drain_cnt_nxt = 2'd0;
               end else begin
                  // Element ends on its terminal address; the next one reloads.
                  w_elem_nxt      = w_elem_inc;
                  w_ctr_load      = 1'b1;
                  w_ctr_load_down = elem_down(w_elem_inc);
               end
            end
         end
         ST_DRAIN: begin
            if (r_drain_cnt == DRAIN_LAST) begin
               w_state_nxt     = ST_DONE;
               w_drain_cnt_nxt = 2'd0;
            end else begin
               w_drain_cnt_nxt = r_drain_cnt + 2'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Bus decode: only RUN drives ops; other states park the bus at zero.
   always_comb begin
      w_address  = '0;
      w_we       = 1'b0;
      w_data_in  = '0;
      w_pipe_cmp = 1'b0;
      w_pipe_exp = '0;
      if (r_state == ST_RUN) begin
         w_address  = w_ctr_count;
         w_we       = w_op_write;
         w_data_in  = w_op_one ? ~BG0 : BG0;
         w_pipe_cmp = ~w_op_write;
         w_pipe_exp = w_op_write ? '0 : w_data_in;
      end
   end

   // Read-latency pipeline for the expected value and compare strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < READ_LAT; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= {w_pipe_exp, w_pipe_cmp};
         for (int i = 1; i < READ_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign bus.Address    = w_address;
   assign bus.WE         = w_we;
   assign bus.Data_in    = w_data_in;
   assign bus.Expected   = r_pipe[READ_LAT-1][DATA_W:1];
   assign bus.Compare_en = r_pipe[READ_LAT-1][0];

   assign Elem    = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) ? r_elem : ELEM_IDLE;
   assign Busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign Done    = (r_state == ST_DONE);
   assign o_state = r_state;

endmodule

// File: tb/tb_march_c_sequencer.sv
// Bench for march_c_sequencer: two instances (READ_LAT=1 and READ_LAT=3)
// share clock, reset and start. Cycle k is the interval after the k-th rising
// edge counted from the edge that samples start (start is high in cycle 0).
module tb_march_c_sequencer;
   import march_pkg::*;

   logic clk;
   logic rst;
   logic start;

   logic [2:0] elem1, elem3;
   logic       busy1, busy3, done1, done3;
   state_t     st1, st3;

   march_c_sequencer_if #(.ADDR_W(8), .DATA_W(4)) bus1 ();
   march_c_sequencer_if #(.ADDR_W(8), .DATA_W(4)) bus3 ();

   march_c_sequencer #(.ADDR_W(8), .DATA_W(4), .READ_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .bus(bus1),
      .Elem(elem1), .Busy(busy1), .Done(done1), .o_state(st1)
   );

   march_c_sequencer #(.ADDR_W(8), .DATA_W(4), .READ_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .bus(bus3),
      .Elem(elem3), .Busy(busy3), .Done(done3), .o_state(st3)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int run_id   = 0;
   int n_cmp0   = 0;
   int n_cmp1   = 0;

   // Scoreboards: expected read data and the cycle its strobe is due.
   logic [3:0] exp_q0[$];
   logic [3:0] exp_q1[$];
   int         due_q0[$];
   int         due_q1[$];

   typedef struct {
      int cyc;
      int dut;    // 0: READ_LAT=1, 1: READ_LAT=3
      int addr;
      int we;
      int data;
      int cmp;
      int expv;   // -1: not checked
      int elem;   // -1: not checked
      int busy;
      int done;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input int c, input int d, input int a, input int w,
                               input int dt, input int cm, input int ev,
                               input int el, input int b, input int dn);
      vec_t v;
      v.cyc = c; v.dut = d; v.addr = a; v.we = w; v.data = dt;
      v.cmp = cm; v.expv = ev; v.elem = el; v.busy = b; v.done = dn;
      return v;
   endfunction

   task automatic check(input string name, input int dut, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s read_lat=%0d cycle=%0d actual=%0d expected=%0d",
                  name, (dut == 0) ? 1 : 3, cyc, act, expv);
      end
   endtask

   // Reference op at cycle k (1..2560) derived from the March C- definition.
   function automatic void model_op(input int k, output int m_elem, output int m_addr,
                                    output bit m_we, output int m_data);
      int j, jj, idx, ph, one;
      if (k <= 256) begin
         m_elem = 0; m_addr = k - 1; m_we = 1'b1; m_data = 0;
      end else if (k <= 2304) begin
         j      = k - 257;
         m_elem = 1 + j / 512;
         jj     = j % 512;
         idx    = jj / 2;
         ph     = jj % 2;
         m_addr = (m_elem >= 3) ? (255 - idx) : idx;
         m_we   = (ph == 1);
         one    = ((m_elem == 1) || (m_elem == 3)) ? ph : (1 - ph);
         m_data = (one != 0) ? 15 : 0;
      end else begin
         m_elem = 5; m_addr = k - 2305; m_we = 1'b0; m_data = 0;
      end
   endfunction

   task automatic check_dut(input int i, input int lat, input int k,
                            input logic [7:0] addr, input logic we, input logic [3:0] data,
                            input logic [3:0] expv, input logic cmp, input logic [2:0] elem,
                            input logic busy, input logic done);
      int m_elem, m_addr, m_data;
      bit m_we;
      bit exp_cmp;
      logic [3:0] exp_data;
      if (k <= 2560) begin
         model_op(k, m_elem, m_addr, m_we, m_data);
         if (!m_we) begin
            if (i == 0) begin exp_q0.push_back(4'(m_data)); due_q0.push_back(k + lat); end
            else        begin exp_q1.push_back(4'(m_data)); due_q1.push_back(k + lat); end
         end
      end else begin
         m_elem = 7; m_addr = 0; m_we = 1'b0; m_data = 0;
      end
      check("address", i, int'(addr), m_addr);
      check("we", i, int'(we), int'(m_we));
      check("data_in", i, int'(data), m_data);

      exp_cmp  = 1'b0;
      exp_data = 4'h0;
      if (i == 0) begin
         if (due_q0.size() > 0 && due_q0[0] == k) begin
            exp_cmp = 1'b1; exp_data = exp_q0.pop_front(); void'(due_q0.pop_front());
         end
      end else begin
         if (due_q1.size() > 0 && due_q1[0] == k) begin
            exp_cmp = 1'b1; exp_data = exp_q1.pop_front(); void'(due_q1.pop_front());
         end
      end
      check("compare_en", i, int'(cmp), int'(exp_cmp));
      if (exp_cmp) check("expected", i, int'(expv), int'(exp_data));
      if (cmp) begin
         if (i == 0) n_cmp0++; else n_cmp1++;
      end

      check("busy", i, int'(busy), (k <= 2560 + lat) ? 1 : 0);
      check("done", i, int'(done), (k >= 2561 + lat) ? 1 : 0);
      if (k <= 2560)             check("elem", i, int'(elem), m_elem);
      else if (k >= 2561 + lat)  check("elem", i, int'(elem), 7);
   endtask

   task automatic apply_vec(input int n, input vec_t v);
      logic [7:0] a; logic w; logic [3:0] d, e; logic c; logic [2:0] el; logic b, dn;
      string tag;
      if (v.dut == 0) begin
         a = bus1.Address; w = bus1.WE; d = bus1.Data_in; e = bus1.Expected;
         c = bus1.Compare_en; el = elem1; b = busy1; dn = done1;
      end else begin
         a = bus3.Address; w = bus3.WE; d = bus3.Data_in; e = bus3.Expected;
         c = bus3.Compare_en; el = elem3; b = busy3; dn = done3;
      end
      tag = $sformatf("vec%0d", n);
      check({tag, "_address"}, v.dut, int'(a), v.addr);
      check({tag, "_we"}, v.dut, int'(w), v.we);
      check({tag, "_data_in"}, v.dut, int'(d), v.data);
      check({tag, "_compare_en"}, v.dut, int'(c), v.cmp);
      if (v.expv >= 0) check({tag, "_expected"}, v.dut, int'(e), v.expv);
      if (v.elem >= 0) check({tag, "_elem"}, v.dut, int'(el), v.elem);
      check({tag, "_busy"}, v.dut, int'(b), v.busy);
      check({tag, "_done"}, v.dut, int'(dn), v.done);
   endtask

   // All outputs at their reset/idle values.
   task automatic check_rest(input string name);
      check({name, "_address"}, 0, int'(bus1.Address), 0);
      check({name, "_we"}, 0, int'(bus1.WE), 0);
      check({name, "_data_in"}, 0, int'(bus1.Data_in), 0);
      check({name, "_expected"}, 0, int'(bus1.Expected), 0);
      check({name, "_compare_en"}, 0, int'(bus1.Compare_en), 0);
      check({name, "_elem"}, 0, int'(elem1), 7);
      check({name, "_busy"}, 0, int'(busy1), 0);
      check({name, "_done"}, 0, int'(done1), 0);
      check({name, "_state"}, 0, int'(st1), int'(ST_IDLE));
      check({name, "_address"}, 1, int'(bus3.Address), 0);
      check({name, "_we"}, 1, int'(bus3.WE), 0);
      check({name, "_data_in"}, 1, int'(bus3.Data_in), 0);
      check({name, "_expected"}, 1, int'(bus3.Expected), 0);
      check({name, "_compare_en"}, 1, int'(bus3.Compare_en), 0);
      check({name, "_elem"}, 1, int'(elem3), 7);
      check({name, "_busy"}, 1, int'(busy3), 0);
      check({name, "_done"}, 1, int'(done3), 0);
      check({name, "_state"}, 1, int'(st3), int'(ST_IDLE));
   endtask

   // Driver: called at a falling edge; start is high in cycle 0 and
   // optionally again during cycle ign (mid-run, must be ignored).
   task automatic run_checked(input int last_cyc, input int ign);
      for (int k = 1; k <= last_cyc; k++) begin
         start = ((k == 1) || (k - 1 == ign)) ? 1'b1 : 1'b0;
         @(negedge clk);
         cyc = k;
         check_dut(0, 1, k, bus1.Address, bus1.WE, bus1.Data_in, bus1.Expected,
                   bus1.Compare_en, elem1, busy1, done1);
         check_dut(1, 3, k, bus3.Address, bus3.WE, bus3.Data_in, bus3.Expected,
                   bus3.Compare_en, elem3, busy3, done3);
         if (run_id == 1) begin
            for (int n = 0; n < 18; n++) begin
               if (vecs[n].cyc == k) apply_vec(n, vecs[n]);
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic clear_sb();
      exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
   endtask

   initial begin
      // Hand-computed checkpoints:        cyc  dut addr we data cmp exp elem busy done
      vecs[0]  = mk(1,    0, 0,   1, 0,  0, -1, 0,  1, 0);
      vecs[1]  = mk(256,  0, 255, 1, 0,  0, -1, 0,  1, 0);
      vecs[2]  = mk(257,  0, 0,   0, 0,  0, -1, 1,  1, 0);
      vecs[3]  = mk(258,  0, 0,   1, 15, 1, 0,  1,  1, 0);
      vecs[4]  = mk(770,  0, 0,   1, 0,  1, 15, 2,  1, 0);
      vecs[5]  = mk(1281, 0, 255, 0, 0,  0, -1, 3,  1, 0);
      vecs[6]  = mk(1792, 0, 0,   1, 15, 1, 0,  3,  1, 0);
      vecs[7]  = mk(1793, 0, 255, 0, 15, 0, -1, 4,  1, 0);
      vecs[8]  = mk(2305, 0, 0,   0, 0,  0, -1, 5,  1, 0);
      vecs[9]  = mk(2560, 0, 255, 0, 0,  1, 0,  5,  1, 0);
      vecs[10] = mk(2561, 0, 0,   0, 0,  1, 0,  -1, 1, 0);
      vecs[11] = mk(2562, 0, 0,   0, 0,  0, -1, 7,  0, 1);
      vecs[12] = mk(1,    1, 0,   1, 0,  0, -1, 0,  1, 0);
      vecs[13] = mk(260,  1, 1,   1, 15, 1, 0,  1,  1, 0);
      vecs[14] = mk(772,  1, 1,   1, 0,  1, 15, 2,  1, 0);
      vecs[15] = mk(2561, 1, 0,   0, 0,  1, 0,  -1, 1, 0);
      vecs[16] = mk(2563, 1, 0,   0, 0,  1, 0,  -1, 1, 0);
      vecs[17] = mk(2564, 1, 0,   0, 0,  0, -1, 7,  0, 1);

      // ---------------- reset and idle ----------------
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_rest("idle");
      end

      // ---------------- full run, table checkpoints ----------------
      run_id = 1;
      run_checked(2570, -1);
      check("compare_count", 0, n_cmp0, 1280);
      check("compare_count", 1, n_cmp1, 1280);
      check("sb_empty", 0, exp_q0.size(), 0);
      check("sb_empty", 1, exp_q1.size(), 0);

      // ---------------- restart from DONE, start pulsed mid-run ----------------
      run_id = 2;
      clear_sb();
      run_checked(899, 500);

      // ---------------- asynchronous reset mid-M2 ----------------
      @(posedge clk);
      cyc = 900;
      #2 rst = 1'b1;
      #1 check_rest("async_rst");
      clear_sb();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 901; i <= 909; i++) begin
         @(negedge clk);
         cyc = i;
         check_rest("post_rst");
      end

      // ---------------- restart after reset ----------------
      run_id = 3;
      run_checked(300, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
